// File: rtl/h264dc_hadamard_pkg.sv
// Shared types and constants for the H.264 DC Hadamard transform.
// The block length depends on the mode latched at the first beat of a block.
package h264dc_pkg;

   typedef enum logic {
      DC_2X2 = 1'b0,
      DC_4X4 = 1'b1
   } dc_mode_e;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      ROWS = 2'd1,
      COLS = 2'd2,
      OUT  = 2'd3
   } state_e;

   localparam int DC_N_2X2 = 4;
   localparam int DC_N_4X4 = 16;

   // Raster index of the final coefficient of a block in the given mode.
   function automatic logic [3:0] dc_last_idx(input dc_mode_e m);
      return (m == DC_4X4) ? 4'(DC_N_4X4 - 1) : 4'(DC_N_2X2 - 1);
   endfunction

endpackage

// File: rtl/h264dc_hadamard_if.sv
// Coefficient stream interface: upstream beats in, transformed results out.
// The master modport is the side that feeds coefficients and consumes results.
interface h264dc_hadamard_if #(
   parameter int IW = 16,
   parameter int OW = IW + 3
);
   logic                 MODE;
   logic                 ENABLE;
   logic signed [IW-1:0] XXIN;
   logic                 READYI;
   logic                 VALID;
   logic signed [OW-1:0] YYOUT;
   logic                 YYLAST;
   logic                 READYO;

   modport master (
      output MODE, ENABLE, XXIN, READYO,
      input  READYI, VALID, YYOUT, YYLAST
   );

   modport slave (
      input  MODE, ENABLE, XXIN, READYO,
      output READYI, VALID, YYOUT, YYLAST
   );
endinterface

// File: rtl/h264dc_butterfly4.sv
// Combinational 4-point Hadamard butterfly, output order matches the H.264
// DC transform rows (sum, low/high split, and the two sign-alternating terms).
module h264dc_butterfly4 #(
   parameter int W = 20
) (
   input  logic signed [W-1:0] i_x0,
   input  logic signed [W-1:0] i_x1,
   input  logic signed [W-1:0] i_x2,
   input  logic signed [W-1:0] i_x3,
   output logic signed [W-1:0] o_y0,
   output logic signed [W-1:0] o_y1,
   output logic signed [W-1:0] o_y2,
   output logic signed [W-1:0] o_y3
);
   logic signed [W-1:0] w_s01;
   logic signed [W-1:0] w_d01;
   logic signed [W-1:0] w_s23;
   logic signed [W-1:0] w_d23;

   assign w_s01 = i_x0 + i_x1;
   assign w_d01 = i_x0 - i_x1;
   assign w_s23 = i_x2 + i_x3;
   assign w_d23 = i_x2 - i_x3;

   assign o_y0 = w_s01 + w_s23;
   assign o_y1 = w_s01 - w_s23;
   assign o_y2 = w_d01 - w_d23;
   assign o_y3 = w_d01 + w_d23;
endmodule

// File: rtl/h264dc_hadamard.sv
// Block-buffered DC Hadamard (2x2 chroma / 4x4 luma): load a block, transform
// it in place with four shared butterflies, then stream it out in raster order.
module h264dc_hadamard
   import h264dc_pkg::*;
#(
   parameter int IW = 16,
   parameter int OW = IW + 3
) (
   input  logic              CLK,
   input  logic              RESET_N,
   h264dc_hadamard_if.slave  bus
);
   localparam int BW = IW + 4;

   state_e              r_state;
   state_e              w_next;
   dc_mode_e            r_mode;
   dc_mode_e            w_mode_eff;
   logic [3:0]          r_cnt;
   logic [3:0]          r_ocnt;
   logic                r_rdy;
   logic                r_vld;
   logic                w_acc;
   logic                w_xfer;
   logic                w_last_in;
   logic                w_last_out;

   logic signed [BW-1:0] r_buf [16];
   logic signed [BW-1:0] w_bx  [4][4];
   logic signed [BW-1:0] w_by  [4][4];

   function automatic logic signed [BW-1:0] half_floor(input logic signed [BW-1:0] v);
      return v >>> 1;
   endfunction

   assign w_acc      = bus.ENABLE & r_rdy;
   assign w_xfer     = r_vld & bus.READYO;
   // Beat 0 decides the block length before mode_q has been written.
   assign w_mode_eff = (r_cnt == 4'd0) ? dc_mode_e'(bus.MODE) : r_mode;
   assign w_last_in  = (r_cnt == dc_last_idx(w_mode_eff));
   assign w_last_out = (r_ocnt == dc_last_idx(r_mode));

   always_comb begin
      w_next = r_state;
      case (r_state)
         LOAD: if (w_acc && w_last_in) w_next = ROWS;
         ROWS: w_next = (r_mode == DC_4X4) ? COLS : OUT;
         COLS: w_next = OUT;
         OUT:  if (w_xfer && w_last_out) w_next = LOAD;
         default: w_next = LOAD;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= LOAD;
         r_mode  <= DC_2X2;
         r_cnt   <= 4'd0;
         r_ocnt  <= 4'd0;
         r_rdy   <= 1'b0;
         r_vld   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_rdy   <= (w_next == LOAD);
         r_vld   <= (w_next == OUT);
         if (w_acc) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd0) r_mode <= dc_mode_e'(bus.MODE);
         end
         if (w_xfer) begin
            if (w_last_out) begin
               r_cnt  <= 4'd0;
               r_ocnt <= 4'd0;
            end else begin
               r_ocnt <= r_ocnt + 4'd1;
            end
         end
      end
   end

   // Butterfly lane l takes row l in ROWS and column l in COLS.
   always_comb begin
      for (int l = 0; l < 4; l++) begin
         for (int k = 0; k < 4; k++) begin
            w_bx[l][k] = (r_state == COLS) ? r_buf[4*k + l] : r_buf[4*l + k];
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_bfly
      h264dc_butterfly4 #(.W(BW)) u_bfly (
         .i_x0 (w_bx[g][0]),
         .i_x1 (w_bx[g][1]),
         .i_x2 (w_bx[g][2]),
         .i_x3 (w_bx[g][3]),
         .o_y0 (w_by[g][0]),
         .o_y1 (w_by[g][1]),
         .o_y2 (w_by[g][2]),
         .o_y3 (w_by[g][3])
      );
   end

   // In-place buffer update; data path carries no reset.
   always_ff @(posedge CLK) begin
      case (r_state)
         LOAD: begin
            if (w_acc) r_buf[r_cnt] <= {{(BW-IW){bus.XXIN[IW-1]}}, bus.XXIN};
         end
         ROWS: begin
            if (r_mode == DC_2X2) begin
               // Lane 0 sees (c00,c01,c10,c11); reorder into f00,f01,f10,f11.
               r_buf[0] <= w_by[0][0];
               r_buf[1] <= w_by[0][3];
               r_buf[2] <= w_by[0][1];
               r_buf[3] <= w_by[0][2];
            end else begin
               for (int l = 0; l < 4; l++) begin
                  for (int k = 0; k < 4; k++) begin
                     r_buf[4*l + k] <= w_by[l][k];
                  end
               end
            end
         end
         COLS: begin
            for (int c = 0; c < 4; c++) begin
               for (int r = 0; r < 4; r++) begin
                  r_buf[4*r + c] <= half_floor(w_by[c][r]);
               end
            end
         end
         default: ;
      endcase
   end

   assign bus.READYI = r_rdy;
   assign bus.VALID  = r_vld;
   assign bus.YYOUT  = r_vld ? r_buf[r_ocnt][OW-1:0] : '0;
   assign bus.YYLAST = r_vld & w_last_out;
endmodule

// File: doc/h264dc_hadamard.md
# h264dc_hadamard

- Parametrised DC-coefficient transform for the H.264 encoder.
- Covers chroma 2x2 DC (4:2:0) and Intra16x16 luma 4x4 DC Hadamard, selected per block.
- Sits between the forward 4x4 core transform's DC collector and DC quantisation.
- Buffers one block, transforms it in place, then streams results in raster order under a ready/valid handshake with backpressure.

## Interface

- IW, 16: input coefficient width, signed two's complement.
- OW, IW+3: output width, signed. Fixed as IW+3; other values are unsupported.
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous reset, active-low. Asserts asynchronously; deassertion is synchronised externally.
- MODE  in  1  0 = 2x2 chroma DC, 1 = 4x4 luma DC. Sampled only on the first accepted beat of a block.
- ENABLE  in  1  input beat offered.
- XXIN  in  IW  input coefficient, raster order (row 0 col 0 first).
- READYI  out  1  block accepts a beat. Reset 0.
- VALID  out  1  YYOUT holds a result. Reset 0.
- YYOUT  out  OW  result coefficient, raster order. Reset 0.
- YYLAST  out  1  qualifies the final coefficient of a block when VALID=1. Reset 0.
- READYO  in  1  downstream accepts YYOUT.

## Operation

- FSM states: LOAD, ROWS, COLS, OUT. Reset state is LOAD.
- LOAD
  - READYI=1.
  - A beat is accepted when ENABLE=1 and READYI=1 on a rising edge. XXIN is stored at buffer index cnt, then cnt increments.
  - Beat 0 latches MODE into mode_q. N = 4 (mode_q=0) or 16 (mode_q=1).
  - Accepting beat N-1 moves to ROWS.
- ROWS
  - 2x2 mode: one cycle computes the full 2x2 result into the buffer, then goes to OUT.
    - f00=a+b+c+d
    - f01=a-b+c-d
    - f10=a+b-c-d
    - f11=a-b-c+d
    - a..d are c00, c01, c10, c11.
  - 4x4 mode: one cycle applies the 1-D 4-point Hadamard to all four rows, then goes to COLS.
    - y0=x0+x1+x2+x3
    - y1=x0+x1-x2-x3
    - y2=x0-x1-x2+x3
    - y3=x0-x1+x2-x3
- COLS (4x4 only): one cycle applies the same 1-D transform to all four columns, then an arithmetic right shift by 1 (floor), then goes to OUT.
- OUT
  - VALID=1; YYOUT = buffer[ocnt], sign-extended to OW.
  - YYLAST=1 when ocnt=N-1.
  - A beat transfers when VALID=1 and READYO=1 on an edge; ocnt then increments.
  - Transferring the final beat clears cnt and ocnt and returns to LOAD.
- Arithmetic: the internal buffer is IW+4 bits signed. Intermediate sums never overflow.
  - 2x2 results fit IW+2 bits; 4x4 results after the shift fit IW+3 bits.
  - No saturation or rounding offset.
- Single-buffered: no new block is accepted until the previous block has fully drained.
- ENABLE while READYI=0 is ignored; the upstream must hold the beat.

## Timing

- READYI and VALID are mutually exclusive, both registered state decodes.
- Latency (2x2): last input accepted at edge E, ROWS occupies cycle E..E+1, VALID high from E+1 with element 0.
- Latency (4x4): last input accepted at edge E, VALID high from E+2.
- Backpressure: while VALID=1 and READYO=0, YYOUT, YYLAST and VALID hold stable. No bubble between consecutive OUT beats when READYO stays high.
- Best-case block period:
  - 2x2: 4 load + 1 transform + 4 out = 9 cycles.
  - 4x4: 16 + 2 + 16 = 34 cycles.
- RESET_N low at any time, including mid-load or mid-output:
  - Immediately clears state to LOAD, cnt/ocnt to 0, and all outputs to reset values.
  - Discards the partial block.
  - Buffer contents need not be cleared.
- MODE changes mid-block have no effect; only the value at beat 0 counts.

## Structure

- Package h264dc_pkg holds:
  - typedef dc_mode_e {DC_2X2, DC_4X4}
  - typedef state_e {LOAD, ROWS, COLS, OUT}
  - constants DC_N_2X2=4 and DC_N_4X4=16.
- Sub-module h264dc_butterfly4: combinational 4-point Hadamard, width parameter W.
- The top instantiates four butterflies, time-shared between row and column passes. 2x2 mode uses the same butterflies with x2=x3=0 on two lanes, or uses dedicated add/sub; implementer's choice.

## Test plan

- 2x2, MODE=0, inputs 1,2,3,4, READYO=1 -> VALID at E+1, outputs 10,-2,-4,0, YYLAST on the 4th.
- 4x4, MODE=1, sixteen inputs all 1 -> outputs 8, then fifteen 0s, first VALID at E+2, YYLAST on the 16th.
- 4x4, input 2 at index 0 and 0 elsewhere -> all sixteen outputs 1. Repeat with -3 at index 0 -> all outputs -2 (floor shift).
- 2x2 inputs 1,2,3,4 with READYO toggling 1,0,0,1,0,1,1 -> YYOUT/YYLAST stable while stalled, exact sequence 10,-2,-4,0, no drops or duplicates.
- RESET_N pulsed low after 7 of 16 beats in 4x4 -> outputs cleared at once. A following 2x2 block 1,2,3,4 -> correct 10,-2,-4,0.
- Back-to-back blocks, MODE flipped mid-block and ENABLE held high through OUT -> READYI=0 during ROWS/COLS/OUT, MODE ignored after beat 0, second block correct.
